regfile_writeback_sink: RTL and testbench

- Receiving end of the writeback interface: the architectural integer register file for the ALU pipeline.
- Accepts the stage-5 writeback triple (Rd_5, writeback_data_5, WriteBack_5) and commits it to storage.
- Serves two registered read ports to the decode stage, with stall hold, flush-to-bubble and x0 hardwired to zero.
- Sits between the stage-5 writeback logic and the stage-2 operand registers.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 55 +++++
 rtl/regfile_writeback_sink.sv | 65 ++++++
 tb/tb_regfile_writeback_sink.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, index/data types and the hardwired-zero index for the integer register file.
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: x0 masking, optional same-cycle writeback forward (REGFILE_WB_BYPASS_EN),
// and the flush/stall output register feeding the stage-2 operand.
module regfile_read_port #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] idx_i,
   input  logic [DATA_W-1:0] stored_i,
   input  logic              wb_en_i,
   input  logic [ADDR_W-1:0] wb_rd_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] data_o
);
   import regfile_pkg::*;

   logic              idx_zero;
   logic [DATA_W-1:0] rdval;
   logic [DATA_W-1:0] data_d, data_q;

   assign idx_zero = (idx_i == ADDR_W'(REG_ZERO));

`ifdef REGFILE_WB_BYPASS_EN
   always_comb begin
      rdval = stored_i;
      if (idx_zero)
         rdval = '0;
      else if (wb_en_i && (wb_rd_i == idx_i))
         rdval = wb_data_i;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_en_i, wb_rd_i, wb_data_i};
   assign rdval     = idx_zero ? '0 : stored_i;
`endif

   // Flush wins over stall so a squashed decode never leaks a held operand.
   always_comb begin
      data_d = data_q;
      if (flush_i)
         data_d = '0;
      else if (!stall_i)
         data_d = rdval;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   assign data_o = data_q;
endmodule

// File: rtl/regfile_writeback_sink.sv
// Architectural integer register file: commits the stage-5 writeback and serves two
// registered decode read ports. Optional forward macro: REGFILE_WB_BYPASS_EN.
module regfile_writeback_sink #(
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS   // must be 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              WriteBack_5,
   input  logic [ADDR_W-1:0] Rd_5,
   input  logic [DATA_W-1:0] writeback_data_5,
   input  logic [ADDR_W-1:0] Rs1_1,
   input  logic [ADDR_W-1:0] Rs2_1,
   input  logic              stall_1,
   input  logic              flush_1,
   output logic [DATA_W-1:0] Rs1_data_2,
   output logic [DATA_W-1:0] Rs2_data_2
);
   import regfile_pkg::*;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   // Entry 0 is never written, so it stays at its reset value and synthesizes away.
   always_comb begin
      regs_d = regs_q;
      if (WriteBack_5 && (Rd_5 != ADDR_W'(REG_ZERO)))
         regs_d[Rd_5] = writeback_data_5;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .idx_i    (Rs1_1),
      .stored_i (regs_q[Rs1_1]),
      .wb_en_i  (WriteBack_5),
      .wb_rd_i  (Rd_5),
      .wb_data_i(writeback_data_5),
      .stall_i  (stall_1),
      .flush_i  (flush_1),
      .data_o   (Rs1_data_2)
   );

   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rs2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .idx_i    (Rs2_1),
      .stored_i (regs_q[Rs2_1]),
      .wb_en_i  (WriteBack_5),
      .wb_rd_i  (Rd_5),
      .wb_data_i(writeback_data_5),
      .stall_i  (stall_1),
      .flush_i  (flush_1),
      .data_o   (Rs2_data_2)
   );
endmodule

// File: tb/tb_regfile_writeback_sink.sv
// Directed bench for regfile_writeback_sink; expected values are hand-computed per scenario.
module tb_regfile_writeback_sink;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              WriteBack_5;
   logic [ADDR_W-1:0] Rd_5;
   logic [DATA_W-1:0] writeback_data_5;
   logic [ADDR_W-1:0] Rs1_1, Rs2_1;
   logic              stall_1, flush_1;
   logic [DATA_W-1:0] Rs1_data_2, Rs2_data_2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   regfile_writeback_sink #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .WriteBack_5     (WriteBack_5),
      .Rd_5            (Rd_5),
      .writeback_data_5(writeback_data_5),
      .Rs1_1           (Rs1_1),
      .Rs2_1           (Rs2_1),
      .stall_1         (stall_1),
      .flush_1         (flush_1),
      .Rs1_data_2      (Rs1_data_2),
      .Rs2_data_2      (Rs2_data_2)
   );

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      WriteBack_5 = 1'b0; Rd_5 = '0; writeback_data_5 = '0;
      Rs1_1 = '0; Rs2_1 = '0; stall_1 = 1'b0; flush_1 = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h0 || Rs2_data_2 !== 32'h0) begin
         n_err++;
         $display("FAIL reset_hold got %h/%h want 0/0", Rs1_data_2, Rs2_data_2);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         Rs1_1 = 5'(i);
         Rs2_1 = 5'(31 - i);
         step();
         n_cmp++;
         if (Rs1_data_2 !== 32'h0 || Rs2_data_2 !== 32'h0) begin
            n_err++;
            $display("FAIL reset_read idx=%0d got %h/%h want 0/0", i, Rs1_data_2, Rs2_data_2);
         end
      end
   endtask

   task automatic test_x0();
      WriteBack_5 = 1'b1; Rd_5 = 5'd0; writeback_data_5 = 32'hDEADBEEF;
      Rs1_1 = 5'd0; Rs2_1 = 5'd0;
      step();
      // Same-cycle read of x0 while x0 is targeted: must be 0 in both builds.
      n_cmp++;
      if (Rs1_data_2 !== 32'h0) begin
         n_err++;
         $display("FAIL x0_same_cycle got %h want 0", Rs1_data_2);
      end
      WriteBack_5 = 1'b0;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h0 || Rs2_data_2 !== 32'h0) begin
         n_err++;
         $display("FAIL x0_read got %h/%h want 0/0", Rs1_data_2, Rs2_data_2);
      end
   endtask

   task automatic test_basic();
      WriteBack_5 = 1'b1; Rd_5 = 5'd5; writeback_data_5 = 32'h12345678;
      step();
      Rd_5 = 5'd31; writeback_data_5 = 32'hFFFFFFFF;
      step();
      WriteBack_5 = 1'b0; Rd_5 = 5'd9; writeback_data_5 = 32'hBAD0BAD0;
      Rs1_1 = 5'd5; Rs2_1 = 5'd31;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h12345678 || Rs2_data_2 !== 32'hFFFFFFFF) begin
         n_err++;
         $display("FAIL basic_rw got %h/%h want 12345678/ffffffff", Rs1_data_2, Rs2_data_2);
      end
      // Disabled writeback must not have touched x9.
      Rs1_1 = 5'd9; Rs2_1 = 5'd5;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h0 || Rs2_data_2 !== 32'h12345678) begin
         n_err++;
         $display("FAIL wb_disabled got %h/%h want 0/12345678", Rs1_data_2, Rs2_data_2);
      end
   endtask

   task automatic test_hazard();
      logic [DATA_W-1:0] exp_fwd;
`ifdef REGFILE_WB_BYPASS_EN
      exp_fwd = 32'h22;
`else
      exp_fwd = 32'h11;
`endif
      WriteBack_5 = 1'b1; Rd_5 = 5'd7; writeback_data_5 = 32'h11;
      Rs1_1 = 5'd0; Rs2_1 = 5'd0;
      step();
      writeback_data_5 = 32'h22;
      Rs1_1 = 5'd7; Rs2_1 = 5'd7;
      step();
      n_cmp++;
      if (Rs1_data_2 !== exp_fwd || Rs2_data_2 !== exp_fwd) begin
         n_err++;
         $display("FAIL hazard_same_cycle got %h/%h want %h", Rs1_data_2, Rs2_data_2, exp_fwd);
      end
      WriteBack_5 = 1'b0;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h22 || Rs2_data_2 !== 32'h22) begin
         n_err++;
         $display("FAIL hazard_after got %h/%h want 22/22", Rs1_data_2, Rs2_data_2);
      end
   endtask

   task automatic test_stall_flush();
      WriteBack_5 = 1'b1; Rd_5 = 5'd10; writeback_data_5 = 32'hA;
      step();
      Rd_5 = 5'd11; writeback_data_5 = 32'hB;
      step();
      WriteBack_5 = 1'b0;
      Rs1_1 = 5'd10; Rs2_1 = 5'd11;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'hA || Rs2_data_2 !== 32'hB) begin
         n_err++;
         $display("FAIL stall_setup got %h/%h want a/b", Rs1_data_2, Rs2_data_2);
      end
      stall_1 = 1'b1;
      WriteBack_5 = 1'b1; Rd_5 = 5'd3; writeback_data_5 = 32'h99;
      Rs1_1 = 5'd5; Rs2_1 = 5'd31;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'hA || Rs2_data_2 !== 32'hB) begin
         n_err++;
         $display("FAIL stall_hold1 got %h/%h want a/b", Rs1_data_2, Rs2_data_2);
      end
      WriteBack_5 = 1'b0;
      Rs1_1 = 5'd3; Rs2_1 = 5'd7;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'hA || Rs2_data_2 !== 32'hB) begin
         n_err++;
         $display("FAIL stall_hold2 got %h/%h want a/b", Rs1_data_2, Rs2_data_2);
      end
      stall_1 = 1'b0;
      Rs1_1 = 5'd3; Rs2_1 = 5'd31;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h99 || Rs2_data_2 !== 32'hFFFFFFFF) begin
         n_err++;
         $display("FAIL stall_write_kept got %h/%h want 99/ffffffff", Rs1_data_2, Rs2_data_2);
      end
      stall_1 = 1'b1; flush_1 = 1'b1;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h0 || Rs2_data_2 !== 32'h0) begin
         n_err++;
         $display("FAIL flush_over_stall got %h/%h want 0/0", Rs1_data_2, Rs2_data_2);
      end
      stall_1 = 1'b0; flush_1 = 1'b0;
      Rs1_1 = 5'd10; Rs2_1 = 5'd11;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'hA || Rs2_data_2 !== 32'hB) begin
         n_err++;
         $display("FAIL post_flush_read got %h/%h want a/b", Rs1_data_2, Rs2_data_2);
      end
      flush_1 = 1'b1;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h0 || Rs2_data_2 !== 32'h0) begin
         n_err++;
         $display("FAIL flush_only got %h/%h want 0/0", Rs1_data_2, Rs2_data_2);
      end
      flush_1 = 1'b0;
   endtask

   task automatic test_async_reset();
      Rs1_1 = 5'd5; Rs2_1 = 5'd31;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h12345678 || Rs2_data_2 !== 32'hFFFFFFFF) begin
         n_err++;
         $display("FAIL areset_setup got %h/%h want 12345678/ffffffff", Rs1_data_2, Rs2_data_2);
      end
      WriteBack_5 = 1'b1; Rd_5 = 5'd4; writeback_data_5 = 32'h44;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (Rs1_data_2 !== 32'h0 || Rs2_data_2 !== 32'h0) begin
         n_err++;
         $display("FAIL areset_immediate got %h/%h want 0/0", Rs1_data_2, Rs2_data_2);
      end
      step();
      rst_n = 1'b1;
      WriteBack_5 = 1'b0;
      Rs1_1 = 5'd4; Rs2_1 = 5'd5;
      step();
      n_cmp++;
      if (Rs1_data_2 !== 32'h0 || Rs2_data_2 !== 32'h0) begin
         n_err++;
         $display("FAIL areset_cleared got %h/%h want 0/0", Rs1_data_2, Rs2_data_2);
      end
   endtask

   initial begin
      test_reset();
      test_x0();
      test_basic();
      test_hazard();
      test_stall_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
